// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : operand_sequencer
// Brief    : Sequences button-loaded operands into a 4-bit adder and captures
//            the 5-bit result.
// Revision : 1.0 - initial release
// ============================================================================

module operand_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       cin_sw,
    input  logic       key_load,
    input  logic [3:0] sum_in,
    input  logic       cout_in,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       cin_out,
    output logic [4:0] result,
    output logic       result_valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_press;

    logic [3:0] r_a,      w_a_next;
    logic [3:0] r_b,      w_b_next;
    logic       r_cin,    w_cin_next;
    logic [4:0] r_result, w_result_next;
    logic       r_valid,  w_valid_next;

    // Metastability chain plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], key_load};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_press = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_A;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_cin    <= 1'b0;
            r_result <= 5'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_cin    <= w_cin_next;
            r_result <= w_result_next;
            r_valid  <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_cin_next    = r_cin;
        w_result_next = r_result;
        w_valid_next  = r_valid;
        case (r_state)
            S_A: begin
                if (w_press) begin
                    w_a_next     = sw;
                    w_valid_next = 1'b0;
                    w_state_next = S_B;
                end
            end
            S_B: begin
                if (w_press) begin
                    w_b_next     = sw;
                    w_cin_next   = cin_sw;
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                // Adder has had a full period to settle; presses here are dropped.
                w_result_next = {cout_in, sum_in};
                w_valid_next  = 1'b1;
                w_state_next  = S_DONE;
            end
            S_DONE: begin
                if (w_press) begin
                    w_state_next = S_A;
                end
            end
            default: begin
                w_state_next = S_A;
            end
        endcase
    end

    assign a_out        = r_a;
    assign b_out        = r_b;
    assign cin_out      = r_cin;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_sequencer
// Brief    : Directed self-checking bench for operand_sequencer.
// Revision : 1.0 - initial release
// ============================================================================

module tb_operand_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic       cin_sw;
    logic       key_load;
    logic [3:0] sum_in;
    logic       cout_in;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       cin_out;
    logic [4:0] result;
    logic       result_valid;
    logic [1:0] state;

    int n_tests;
    int n_fail;
    int n_trans;
    logic [1:0] prev_state;

    operand_sequencer #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .cin_sw       (cin_sw),
        .key_load     (key_load),
        .sum_in       (sum_in),
        .cout_in      (cout_in),
        .a_out        (a_out),
        .b_out        (b_out),
        .cin_out      (cin_out),
        .result       (result),
        .result_valid (result_valid),
        .state        (state)
    );

    // Downstream combinational ripple adder.
    assign {cout_in, sum_in} = {1'b0, a_out} + {1'b0, b_out} + {4'd0, cin_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge right after the press has taken effect.
    task automatic press(input logic [3:0] v, input logic c);
        repeat (2) @(negedge clk);
        sw       = v;
        cin_sw   = c;
        key_load = 1'b1;
        repeat (3) @(negedge clk);
        key_load = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        key_load = 1'b0;
        sw       = 4'd0;
        cin_sw   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_cin", cin_out, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        reset = 1'b1;
        @(negedge clk);

        // Two-edge synchronizer latency on the first press.
        sw       = 4'd3;
        key_load = 1'b1;
        @(negedge clk);
        check("lat_k", state, 0);
        @(negedge clk);
        check("lat_k1", state, 0);
        @(negedge clk);
        check("lat_k2", state, 1);
        check("load_a3", a_out, 3);
        key_load = 1'b0;
        sw       = 4'd9;

        press(4'd5, 1'b0);
        check("add_state", state, 2);
        check("load_b5", b_out, 5);
        check("load_cin0", cin_out, 0);
        check("add_valid0", result_valid, 0);
        sw = 4'hA;
        @(negedge clk);
        check("done_state", state, 3);
        check("res_3p5", result, 5'h08);
        check("valid_3p5", result_valid, 1);
        for (int i = 0; i < 3; i++) begin
            sw     = ~sw;
            cin_sw = ~cin_sw;
            @(negedge clk);
            check("hold_a", a_out, 3);
            check("hold_b", b_out, 5);
            check("hold_res", result, 5'h08);
        end

        press(4'd7, 1'b0);
        check("done_to_a", state, 0);
        check("done_valid_kept", result_valid, 1);
        check("done_res_kept", result, 5'h08);

        press(4'hF, 1'b0);
        check("a_F", a_out, 4'hF);
        check("valid_clr", result_valid, 0);
        press(4'h1, 1'b1);
        @(negedge clk);
        check("res_F11", result, 5'h11);
        check("res_F11_st", state, 3);

        press(4'd0, 1'b0);
        press(4'hF, 1'b0);
        press(4'h1, 1'b0);
        @(negedge clk);
        check("res_F10", result, 5'h10);

        // Key held 20 cycles in S_A yields a single transition.
        press(4'd0, 1'b0);
        check("hold_start_a", state, 0);
        @(negedge clk);
        sw         = 4'd6;
        key_load   = 1'b1;
        n_trans    = 0;
        prev_state = state;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state != prev_state) n_trans++;
            prev_state = state;
        end
        key_load = 1'b0;
        check("hold_trans", n_trans, 1);
        check("hold_state", state, 1);
        check("hold_a6", a_out, 6);
        check("hold_b_kept", b_out, 1);

        // Reset asserted mid-S_ADD aborts with no capture.
        press(4'd2, 1'b0);
        check("pre_rst_add", state, 2);
        reset = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_a", a_out, 0);
        check("arst_b", b_out, 0);
        check("arst_result", result, 0);
        check("arst_valid", result_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_state", state, 0);
        check("post_rst_valid", result_valid, 0);
        check("post_rst_result", result, 0);

        // Key already high through reset propagates through cleared flops.
        reset    = 1'b0;
        key_load = 1'b1;
        sw       = 4'd4;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rk_e1", state, 0);
        @(negedge clk);
        check("rk_e2", state, 0);
        @(negedge clk);
        check("rk_e3", state, 1);
        check("rk_a4", a_out, 4);
        key_load = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
